// File: rtl/fan_tach_monitor_pkg.sv
// Shared FSM state type, default parameter values and counter-width helper
// for the fan tach monitor.
package fan_tach_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPINUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_STALL  = 2'd3
    } fan_state_e;

    localparam int DEF_GATE_CYCLES     = 250000;
    localparam int DEF_COUNT_BITWIDTH  = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_STALL_MIN       = 2;
    localparam int DEF_STALL_GATES     = 3;
    localparam int DEF_SPINUP_GATES    = 2;

    // Bits needed to hold every value in 0..max_val, never fewer than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tach_debounce.sv
// Two-flop synchroniser plus debouncer for the open-collector tach line;
// the accepted level idles high and flips only after a full stable run.
module tach_debounce
    import fan_tach_monitor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw,
    output logic level
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive synchronised samples that disagree with the accepted level.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers; sync stages reset high so release produces no false edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/fan_tach_monitor.sv
// Fan tach monitor: gated falling-edge count, spin-up/run/stall FSM.
// Define TACH_STALL_FORCE_EN to force pwm_o high while stalled.
module fan_tach_monitor
    import fan_tach_monitor_pkg::*;
#(
    parameter int GATE_CYCLES     = DEF_GATE_CYCLES,
    parameter int COUNT_BITWIDTH  = DEF_COUNT_BITWIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STALL_MIN       = DEF_STALL_MIN,
    parameter int STALL_GATES     = DEF_STALL_GATES,
    parameter int SPINUP_GATES    = DEF_SPINUP_GATES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      pwm_i,
    input  logic                      tach_i,
    input  logic                      stall_clr_i,
    output logic                      pwm_o,
    output logic [COUNT_BITWIDTH-1:0] count_o,
    output logic                      count_valid_o,
    output logic                      stall_o
);

    localparam int            GW        = cnt_width(GATE_CYCLES - 1);
    localparam int            SW        = cnt_width(SPINUP_GATES);
    localparam int            LW        = cnt_width(STALL_GATES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] SPIN_LOAD = SW'(SPINUP_GATES);
    localparam logic [LW-1:0] LOW_LIMIT = LW'(STALL_GATES);

    fan_state_e                state_q, state_d;
    logic [GW-1:0]             gate_cnt_q, gate_cnt_d;
    logic [COUNT_BITWIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [COUNT_BITWIDTH-1:0] count_q, count_d;
    logic [SW-1:0]             spin_cnt_q, spin_cnt_d;
    logic [LW-1:0]             low_cnt_q, low_cnt_d;
    logic                      level_prev_q, level_prev_d;
    logic                      pwm_seen_q, pwm_seen_d;
    logic                      valid_q, valid_d;
    logic                      stall_q, stall_d;
    logic                      level_s, wrap_s, fall_s, active_s, low_s;

    tach_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .raw  (tach_i),
        .level(level_s)
    );

    // Gate timing, edge counting and the per-gate result register.
    always_comb begin
        wrap_s       = (gate_cnt_q == GATE_LAST);
        fall_s       = level_prev_q & ~level_s;
        active_s     = pwm_seen_q | pwm_i;
        // A saturated count means the fan is clearly spinning.
        low_s        = (32'(pulse_cnt_q) < 32'(STALL_MIN)) && (pulse_cnt_q != '1);
        level_prev_d = level_s;
        gate_cnt_d   = wrap_s ? '0 : gate_cnt_q + GW'(1);
        pwm_seen_d   = wrap_s ? 1'b0 : active_s;
        valid_d      = wrap_s;
        count_d      = count_q;
        pulse_cnt_d  = pulse_cnt_q;
        if (wrap_s) begin
            count_d     = pulse_cnt_q;
            pulse_cnt_d = COUNT_BITWIDTH'(fall_s);
        end else if (fall_s && (pulse_cnt_q != '1)) begin
            pulse_cnt_d = pulse_cnt_q + COUNT_BITWIDTH'(1);
        end else begin
            pulse_cnt_d = pulse_cnt_q;
        end
    end

    // Supervisory FSM: advances only at gate wrap, except the stall clear.
    always_comb begin
        state_d    = state_q;
        spin_cnt_d = spin_cnt_q;
        low_cnt_d  = low_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (wrap_s && active_s) begin
                    state_d    = ST_SPINUP;
                    spin_cnt_d = SPIN_LOAD;
                    low_cnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SPINUP: begin
                if (!wrap_s) begin
                    state_d = ST_SPINUP;
                end else if (!active_s) begin
                    state_d    = ST_IDLE;
                    spin_cnt_d = '0;
                end else if (spin_cnt_q <= SW'(1)) begin
                    state_d    = ST_RUN;
                    spin_cnt_d = '0;
                    low_cnt_d  = '0;
                end else begin
                    spin_cnt_d = spin_cnt_q - SW'(1);
                end
            end
            ST_RUN: begin
                if (!wrap_s) begin
                    state_d = ST_RUN;
                end else if (!active_s) begin
                    state_d   = ST_IDLE;
                    low_cnt_d = '0;
                end else if (!low_s) begin
                    low_cnt_d = '0;
                end else if ((low_cnt_q + LW'(1)) >= LOW_LIMIT) begin
                    state_d   = ST_STALL;
                    low_cnt_d = LOW_LIMIT;
                end else begin
                    low_cnt_d = low_cnt_q + LW'(1);
                end
            end
            ST_STALL: begin
                if (stall_clr_i) begin
                    state_d    = ST_IDLE;
                    low_cnt_d  = '0;
                    spin_cnt_d = '0;
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        stall_d = (state_d == ST_STALL);
    end

    // All state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            gate_cnt_q   <= '0;
            pulse_cnt_q  <= '0;
            count_q      <= '0;
            spin_cnt_q   <= '0;
            low_cnt_q    <= '0;
            level_prev_q <= 1'b1;
            pwm_seen_q   <= 1'b0;
            valid_q      <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            count_q      <= count_d;
            spin_cnt_q   <= spin_cnt_d;
            low_cnt_q    <= low_cnt_d;
            level_prev_q <= level_prev_d;
            pwm_seen_q   <= pwm_seen_d;
            valid_q      <= valid_d;
            stall_q      <= stall_d;
        end
    end

    assign count_o       = count_q;
    assign count_valid_o = valid_q;
    assign stall_o       = stall_q;

`ifdef TACH_STALL_FORCE_EN
    assign pwm_o = pwm_i | (state_q == ST_STALL);
`else
    assign pwm_o = pwm_i;
`endif

endmodule
